// File: rtl/sram_fifo_ctrl_if.sv
// rtl/sram_fifo_ctrl_if.sv - request, sram drive and status signals of the sram FIFO controller
interface sram_fifo_ctrl_if #(
    parameter int addr_width = 6
);
    // requests from the producer/consumer side
    logic                  wr_en;
    logic                  rd_en;
    logic                  err_clr;
    // strobes and addresses toward the dual-port sram
    logic                  sram_wr_en;
    logic [addr_width-1:0] sram_wr_addr;
    logic                  sram_rd_en;
    logic [addr_width-1:0] sram_rd_addr;
    // status
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [addr_width:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, rd_en, err_clr,
        input  sram_wr_en, sram_wr_addr, sram_rd_en, sram_rd_addr,
        input  rd_valid, full, empty, almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, err_clr,
        output sram_wr_en, sram_wr_addr, sram_rd_en, sram_rd_addr,
        output rd_valid, full, empty, almost_full, almost_empty, count,
        output overflow, underflow
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - single-clock FIFO controller using a dual-port sram as backing store
module sram_fifo_ctrl #(
    parameter int addr_width       = 6,
    parameter int depth            = 64,
    parameter int almost_full_gap  = 50,
    parameter int almost_empty_gap = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    sram_fifo_ctrl_if.slave  bus
);
    localparam logic [addr_width:0]   depth_c  = (addr_width+1)'(depth);
    localparam logic [addr_width:0]   af_c     = (addr_width+1)'(almost_full_gap);
    localparam logic [addr_width:0]   ae_c     = (addr_width+1)'(almost_empty_gap);
    localparam logic [addr_width-1:0] last_ptr = addr_width'(depth - 1);

    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [addr_width:0]   count_q;
    logic                  rd_valid_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full_w;
    logic                  empty_w;
    logic                  push;
    logic                  pop;

    // Flags come from the count register only, so requests never reach them combinationally.
    assign full_w  = (count_q == depth_c);
    assign empty_w = (count_q == '0);

    // A request is accepted only against registered state; a pop never sees a same-cycle push.
    assign push = bus.wr_en & ~full_w;
    assign pop  = bus.rd_en & ~empty_w;

    assign bus.sram_wr_en   = push;
    assign bus.sram_wr_addr = wr_ptr;
    assign bus.sram_rd_en   = pop;
    assign bus.sram_rd_addr = rd_ptr;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= af_c);
    assign bus.almost_empty = (count_q <= ae_c);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // Pointers wrap explicitly at depth-1 so depth need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Occupancy moves only when exactly one side is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // rd_valid is the registered pop, lining up with the sram read data one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_valid_q <= 1'b0;
        else        rd_valid_q <= pop;
    end

    // Sticky error flags; a new error event outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en & full_w)  overflow_q  <= 1'b1;
            else if (bus.err_clr)    overflow_q  <= 1'b0;
            if (bus.rd_en & empty_w) underflow_q <= 1'b1;
            else if (bus.err_clr)    underflow_q <= 1'b0;
        end
    end
endmodule
